// File: rtl/booth_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mult_seq_pkg
//  Purpose  : Shared types and constants for the sequential Booth multiplier.
//             - state_e   : FSM state encoding (IDLE / BUSY / DONE)
//             - cnt_width : step-counter width for a given operand width
//  Revision : 1.0  initial release
// ============================================================================
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_seq_step.sv
`default_nettype none
// ============================================================================
//  Module   : booth_step
//  Purpose  : One combinational radix-2 Booth iteration: add/subtract the
//             multiplicand according to {Q[0],q_1}, then arithmetic right
//             shift of {A,Q,q_1} by one bit.
//  Ports    : a_i  [WIDTH:0]   partial product accumulator A
//             q_i  [WIDTH-1:0] multiplier / low product bits Q
//             q1_i             previous LSB of Q
//             m_i  [WIDTH:0]   sign-extended multiplicand M
//             a_o, q_o, q1_o   updated A, Q, q_1
//  Revision : 1.0  initial release
// ============================================================================
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    unique case ({q_i[0], q1_i})
      2'b01:   w_sum = a_i + m_i;
      2'b10:   w_sum = a_i - m_i;
      default: w_sum = a_i;
    endcase
  end

  // Arithmetic shift: A's sign bit is replicated, A's LSB moves into Q.
  assign a_o  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign q_o  = {w_sum[0], q_i[WIDTH-1:1]};
  assign q1_o = q_i[0];

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mult_seq
//  Purpose  : Sequential radix-2 Booth multiplier for signed operands with a
//             start/done handshake. One Booth step per clock; the product is
//             registered on r with done=1 and held until the next accept.
//  Ports    : clk    rising-edge clock
//             reset  synchronous active-high reset
//             start  request, accepted in IDLE or DONE
//             a, b   signed multiplicand / multiplier, sampled on accept
//             r      signed product a*b (2*WIDTH bits), valid while done=1
//             done   result valid / ready
//  Revision : 1.0  initial release
// ============================================================================
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] r,
  output logic               done
);

  localparam int                 CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] r_q, r_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   mq_n;
  logic               q1_n;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i  (acc_q),
    .q_i  (mq_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (acc_n),
    .q_o  (mq_n),
    .q1_o (q1_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = done_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Extra sign bit on M/A keeps -2^(WIDTH-1) operands from overflowing.
          m_d     = {a[WIDTH-1], a};
          acc_d   = '0;
          mq_d    = b;
          q1_d    = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = acc_n;
        mq_d  = mq_n;
        q1_d  = q1_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          r_d     = {acc_n[WIDTH-1:0], mq_n};
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign r    = r_q;
  assign done = done_q;

endmodule
`default_nettype wire
